// File: rtl/branch_recovery_ctrl.sv
// rtl/branch_recovery_ctrl.sv - branch misprediction recovery sequencer for the dual-issue core
// Picks the oldest mispredicted slot, holds the redirect until fetch takes it, then drains the front end.
module branch_recovery_ctrl #(
  parameter int PC_W         = 11,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validE1,
  input  logic             validE2,
  input  logic             PredictionE1,
  input  logic             PredictionE2,
  input  logic             branch_taken1,
  input  logic             branch_taken2,
  input  logic [PC_W-1:0]  PCE1,
  input  logic [PC_W-1:0]  PCE2,
  input  logic [PC_W-1:0]  branchAdderResultE1,
  input  logic [PC_W-1:0]  branchAdderResultE2,
  input  logic             fetch_ready,
  output logic             pc_redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_front,
  output logic             flush_slot2E,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : CW'(0);

  typedef enum logic [1:0] {IDLE, WAIT_FETCH, FLUSH} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            mis1, mis2, accept;
  logic [PC_W-1:0] tgt1, tgt2, sel_tgt;

  // A mispredicted not-taken branch resumes at the fall-through PC, wrapping at the top.
  assign mis1    = validE1 & (branch_taken1 != PredictionE1);
  assign mis2    = validE2 & (branch_taken2 != PredictionE2);
  assign tgt1    = branch_taken1 ? branchAdderResultE1 : PCE1 + PC_W'(1);
  assign tgt2    = branch_taken2 ? branchAdderResultE2 : PCE2 + PC_W'(1);
  assign sel_tgt = mis1 ? tgt1 : tgt2;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (mis1 | mis2) begin
          accept     = 1'b1;
          state_next = WAIT_FETCH;
        end
      end
      WAIT_FETCH: begin
        if (fetch_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next = FLUSH;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      FLUSH: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_redirect  = (state == WAIT_FETCH);
  assign flush_front  = (state != IDLE);
  assign busy         = (state != IDLE);
  // Slot 2 is younger than a mispredicted slot 1, so it is on the wrong path.
  assign flush_slot2E = ~reset & (state == IDLE) & mis1 & validE2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        redirect_pc <= sel_tgt;
        if (mispredict_count != {CNT_W{1'b1}})
          mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// tb/tb_branch_recovery_ctrl.sv - scoreboard bench for branch_recovery_ctrl
// Two instances share stimulus: default build and a FLUSH_CYCLES=0, CNT_W=2 build.
module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        validE1, validE2, PredictionE1, PredictionE2, branch_taken1, branch_taken2;
  logic [10:0] PCE1, PCE2, branchAdderResultE1, branchAdderResultE2;
  logic        fetch_ready;

  logic        pc_redirect1, flush_front1, flush_slot2E1, busy1;
  logic [10:0] redirect_pc1;
  logic [15:0] count1;
  logic        pc_redirect2, flush_front2, flush_slot2E2, busy2;
  logic [10:0] redirect_pc2;
  logic [1:0]  count2;

  typedef struct packed {
    logic [10:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_recovery_ctrl #(.PC_W(11), .FLUSH_CYCLES(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .validE1(validE1), .validE2(validE2),
    .PredictionE1(PredictionE1), .PredictionE2(PredictionE2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .PCE1(PCE1), .PCE2(PCE2),
    .branchAdderResultE1(branchAdderResultE1), .branchAdderResultE2(branchAdderResultE2),
    .fetch_ready(fetch_ready),
    .pc_redirect(pc_redirect1), .redirect_pc(redirect_pc1), .flush_front(flush_front1),
    .flush_slot2E(flush_slot2E1), .busy(busy1), .mispredict_count(count1)
  );

  branch_recovery_ctrl #(.PC_W(11), .FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .validE1(validE1), .validE2(validE2),
    .PredictionE1(PredictionE1), .PredictionE2(PredictionE2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .PCE1(PCE1), .PCE2(PCE2),
    .branchAdderResultE1(branchAdderResultE1), .branchAdderResultE2(branchAdderResultE2),
    .fetch_ready(fetch_ready),
    .pc_redirect(pc_redirect2), .redirect_pc(redirect_pc2), .flush_front(flush_front2),
    .flush_slot2E(flush_slot2E2), .busy(busy2), .mispredict_count(count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [10:0] pc, input logic [15:0] cnt);
    exp_t e;
    e.pc  = pc;
    e.cnt = cnt;
    return e;
  endfunction

  // Monitors: every redirect cycle must show the queued target; the handshake pops it.
  always @(negedge clk) begin
    if (!reset && pc_redirect1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_redirect: got pc 0x%0h expected no redirect", redirect_pc1);
      end else begin
        chk("dut1_redirect_pc", 32'(redirect_pc1), 32'(q1[0].pc));
        if (fetch_ready) begin
          chk("dut1_count_at_accept", 32'(count1), 32'(q1[0].cnt));
          void'(q1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && pc_redirect2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2_unexpected_redirect: got pc 0x%0h expected no redirect", redirect_pc2);
      end else begin
        chk("dut2_redirect_pc", 32'(redirect_pc2), 32'(q2[0].pc));
        if (fetch_ready) begin
          chk("dut2_count_at_accept", 32'(count2), 32'(q2[0].cnt));
          void'(q2.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    validE1 = 0; validE2 = 0; PredictionE1 = 0; PredictionE2 = 0;
    branch_taken1 = 0; branch_taken2 = 0;
    PCE1 = '0; PCE2 = '0; branchAdderResultE1 = '0; branchAdderResultE2 = '0;
    fetch_ready = 1;
  endtask

  task automatic set1(input logic pred, input logic taken, input logic [10:0] pc, input logic [10:0] tgt);
    validE1 = 1; PredictionE1 = pred; branch_taken1 = taken; PCE1 = pc; branchAdderResultE1 = tgt;
  endtask

  task automatic set2(input logic pred, input logic taken, input logic [10:0] pc, input logic [10:0] tgt);
    validE2 = 1; PredictionE2 = pred; branch_taken2 = taken; PCE2 = pc; branchAdderResultE2 = tgt;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      clr();
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    clr();
    reset = 1;
    // Reset held with a both-slot mispredict presented: nothing may react.
    tick();
    set1(0, 1, 11'h010, 11'h007);
    set2(0, 1, 11'h020, 11'h008);
    @(negedge clk);
    chk("reset_flush_slot2E_d1", 32'(flush_slot2E1), 0);
    chk("reset_flush_slot2E_d2", 32'(flush_slot2E2), 0);
    tick();
    clr();
    @(negedge clk);
    chk("reset_pc_redirect", 32'(pc_redirect1), 0);
    chk("reset_flush_front", 32'(flush_front1), 0);
    chk("reset_busy", 32'(busy1), 0);
    chk("reset_count", 32'(count1), 0);
    chk("reset_redirect_pc", 32'(redirect_pc1), 0);
    chk("reset_busy_d2", 32'(busy2), 0);

    // Slot 1 mispredicted taken.
    tick();
    reset = 0;
    set1(0, 1, 11'h010, 11'h123);
    q1.push_back(mk(11'h123, 16'd1));
    q2.push_back(mk(11'h123, 16'd1));
    @(negedge clk);
    chk("t1_flush_slot2E", 32'(flush_slot2E1), 0);
    chk("t1_busy_T", 32'(busy1), 0);
    tick(); clr();
    @(negedge clk);
    chk("t1_pc_redirect_T1", 32'(pc_redirect1), 1);
    chk("t1_flush_front_T1", 32'(flush_front1), 1);
    chk("t1_busy_T1", 32'(busy1), 1);
    chk("t1_redirect_pc_T1", 32'(redirect_pc1), 32'h123);
    tick(); clr();
    @(negedge clk);
    chk("t1_pc_redirect_T2", 32'(pc_redirect1), 0);
    chk("t1_flush_front_T2", 32'(flush_front1), 1);
    chk("t1_zero_flush_idle_d2", 32'(busy2), 0);
    tick(); clr();
    @(negedge clk);
    chk("t1_pc_redirect_T3", 32'(pc_redirect1), 0);
    chk("t1_flush_front_T3", 32'(flush_front1), 1);
    tick(); clr();
    @(negedge clk);
    chk("t1_busy_T4", 32'(busy1), 0);
    chk("t1_flush_front_T4", 32'(flush_front1), 0);
    chk("t1_count_T4", 32'(count1), 1);

    // Both slots mispredict; slot 1 wins with a wrapping fall-through target.
    tick();
    set1(1, 0, 11'h7FF, 11'h222);
    set2(0, 1, 11'h100, 11'h555);
    q1.push_back(mk(11'h000, 16'd2));
    q2.push_back(mk(11'h000, 16'd2));
    @(negedge clk);
    chk("t2_flush_slot2E_d1", 32'(flush_slot2E1), 1);
    chk("t2_flush_slot2E_d2", 32'(flush_slot2E2), 1);
    idle_cycles(4);

    // Only slot 2 mispredicts; slot 1 valid but correctly predicted.
    tick();
    set1(1, 1, 11'h030, 11'h333);
    set2(1, 0, 11'h040, 11'h444);
    q1.push_back(mk(11'h041, 16'd3));
    q2.push_back(mk(11'h041, 16'd3));
    @(negedge clk);
    chk("t3_flush_slot2E", 32'(flush_slot2E1), 0);
    idle_cycles(4);

    // Fetch backpressure with a wrong-path mispredict during the wait.
    tick();
    set1(0, 1, 11'h050, 11'h2AA);
    fetch_ready = 0;
    q1.push_back(mk(11'h2AA, 16'd4));
    q2.push_back(mk(11'h2AA, 16'd3));
    tick(); clr(); fetch_ready = 0;
    @(negedge clk);
    chk("t4_pc_redirect_W1", 32'(pc_redirect1), 1);
    tick(); clr(); fetch_ready = 0;
    set1(0, 1, 11'h060, 11'h111);
    set2(0, 1, 11'h070, 11'h0EE);
    @(negedge clk);
    chk("t4_pc_redirect_W2", 32'(pc_redirect1), 1);
    chk("t4_no_slot2_flush_busy", 32'(flush_slot2E1), 0);
    tick(); clr(); fetch_ready = 0;
    @(negedge clk);
    chk("t4_pc_redirect_W3", 32'(pc_redirect1), 1);
    tick(); clr();
    @(negedge clk);
    chk("t4_pc_redirect_W4", 32'(pc_redirect1), 1);
    tick(); clr();
    @(negedge clk);
    chk("t4_flush_pc_redirect", 32'(pc_redirect1), 0);
    chk("t4_flush_front", 32'(flush_front1), 1);
    idle_cycles(2);
    @(negedge clk);
    chk("t4_busy_end", 32'(busy1), 0);
    chk("t4_count_end", 32'(count1), 4);
    chk("t4_redirect_pc_kept", 32'(redirect_pc1), 32'h2AA);
    chk("t4_count_d2_sat", 32'(count2), 3);

    // Reset in the middle of FLUSH, then an immediate slot 2 mispredict.
    tick();
    set1(0, 1, 11'h080, 11'h0AB);
    q1.push_back(mk(11'h0AB, 16'd5));
    q2.push_back(mk(11'h0AB, 16'd3));
    tick(); clr();
    tick(); clr();
    @(negedge clk);
    chk("t5_in_flush", 32'(flush_front1), 1);
    reset = 1;
    tick(); clr();
    reset = 0;
    set2(0, 1, 11'h090, 11'h3CC);
    q1.push_back(mk(11'h3CC, 16'd1));
    q2.push_back(mk(11'h3CC, 16'd1));
    @(negedge clk);
    chk("t5_rst_pc_redirect", 32'(pc_redirect1), 0);
    chk("t5_rst_flush_front", 32'(flush_front1), 0);
    chk("t5_rst_busy", 32'(busy1), 0);
    chk("t5_rst_count", 32'(count1), 0);
    chk("t5_rst_redirect_pc", 32'(redirect_pc1), 0);
    tick(); clr();
    @(negedge clk);
    chk("t5_post_rst_redirect", 32'(pc_redirect1), 1);
    chk("t5_post_rst_count", 32'(count1), 1);
    idle_cycles(3);
    @(negedge clk);
    chk("t5_busy_end", 32'(busy1), 0);

    // Saturation on the 2-bit counter: one mispredict every two cycles.
    tick(); clr();
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      set1(0, 1, 11'h0F0, 11'(11'h100 + k));
      q2.push_back(mk(11'(11'h100 + k), 16'((k < 3) ? k + 1 : 3)));
      if (k % 2 == 0) q1.push_back(mk(11'(11'h100 + k), 16'(k / 2 + 1)));
      tick(); clr();
      @(negedge clk);
      chk("t6_sat_count_d2", 32'(count2), 32'((k < 3) ? k + 1 : 3));
      tick();
    end
    clr();
    idle_cycles(4);
    @(negedge clk);
    chk("t6_count_d1", 32'(count1), 3);
    chk("t6_count_d2", 32'(count2), 3);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
